// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage sitting in front of the IF/ID pipeline register.
// It owns the fetch PC, issues word requests to instruction memory over a
// valid/ready channel, buffers the in-order responses in a small queue and
// presents each instruction together with its own PC to the decode stage.
// Decode can stall the head of the queue, and a taken branch/jump redirect
// flushes both the queue and every fetch that is still in flight.
//
// Parameters:
//   RESET_PC        fetch PC loaded on reset
//   QDEPTH          queue entries, also the cap on outstanding requests
//                   (power of 2, >= 2)
//
// Ports:
//   clk             clock, all state changes on its rising edge
//   reset           synchronous, active-high reset
//   imem_req_valid  fetch request valid
//   imem_req_ready  imem accepts the request this cycle
//   imem_req_addr   word-aligned fetch address
//   imem_resp_valid response valid, in request order, >= 1 cycle after accept
//   imem_resp_data  fetched instruction word
//   redirect_valid  branch/jump taken: flush and refetch from redirect_pc
//   redirect_pc     redirect target (low two bits ignored)
//   stall           decode cannot accept an instruction this cycle
//   instr_valid     instr/instr_pc hold a valid instruction
//   instr           instruction at the queue head (0 when empty)
//   instr_pc        address of instr (0 when empty)
//   stall_cycles    only with IF_STALL_COUNT_EN: saturating count of cycles
//                   in which a valid instruction was held by stall
//
// Optional feature macro: IF_STALL_COUNT_EN
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
`ifdef IF_STALL_COUNT_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(QDEPTH);

    logic [31:0]   pc;
    logic [31:0]   resp_pc;
    logic [31:0]   q_data [QDEPTH];
    logic [31:0]   q_pc   [QDEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic          reset_d;

    logic [CW:0]   in_use;
    logic          req_fire;
    logic          resp_drop;
    logic          push;
    logic          pop;

    // Request issue is reserved against queue space: every in-flight fetch
    // already owns a queue slot, so a response can always be stored.
    // reset_d keeps the request channel quiet for one cycle after reset.
    // Responses still owed to a flushed fetch stream are swallowed while
    // drop_cnt is non-zero.
    always_comb begin
        in_use         = {1'b0, count} + {1'b0, outstanding};
        imem_req_valid = !reset && !reset_d && !redirect_valid && (in_use < DEPTH_LIM);
        imem_req_addr  = pc;
        req_fire       = imem_req_valid && imem_req_ready;
        resp_drop      = imem_resp_valid && (drop_cnt != '0);
        push           = imem_resp_valid && (drop_cnt == '0) && !redirect_valid;
        instr_valid    = !reset && (count != '0);
        pop            = instr_valid && !stall && !redirect_valid;
        instr          = instr_valid ? q_data[head] : '0;
        instr_pc       = instr_valid ? q_pc[head]   : '0;
    end

    // Control state. resp_pc tracks the address of the next response that
    // will be kept, so each queue entry is tagged with its own PC without a
    // separate FIFO of issued addresses. A redirect reloads drop_cnt with all
    // fetches still owed after this cycle, which also covers a redirect that
    // lands while an earlier flush is still draining.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            reset_d     <= 1'b1;
        end else begin
            reset_d     <= 1'b0;
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_resp_valid);
            if (redirect_valid) begin
                pc       <= redirect_pc & ~32'h3;
                resp_pc  <= redirect_pc & ~32'h3;
                head     <= '0;
                tail     <= '0;
                count    <= '0;
                drop_cnt <= outstanding - CW'(imem_resp_valid);
            end else begin
                if (req_fire) begin
                    pc <= pc + 32'd4;
                end
                if (resp_drop) begin
                    drop_cnt <= drop_cnt - 1'b1;
                end
                if (push) begin
                    tail    <= tail + 1'b1;
                    resp_pc <= resp_pc + 32'd4;
                end
                if (pop) begin
                    head <= head + 1'b1;
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Queue storage needs no reset; validity is carried by count.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            q_data[tail] <= imem_resp_data;
            q_pc[tail]   <= resp_pc;
        end
    end

`ifdef IF_STALL_COUNT_EN
    // Counts cycles where decode held back a valid instruction; a redirect
    // cycle is not a stall because the head is being discarded anyway.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (instr_valid && stall && !redirect_valid && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

    // A kept response arriving with the queue already full means the
    // reservation accounting has gone wrong.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        push |-> ({1'b0, count} != DEPTH_LIM));

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Self-checking bench for fetch_unit. A behavioural instruction memory
// answers accepted requests in order after a configurable latency, with
// data derived from the address. Directed scenarios cover reset, streaming,
// stall backpressure, redirect flush, request backpressure, PC wrap and the
// optional stall counter; a randomized run checks the delivered instruction
// stream against a simple "sequential from the last redirect" model.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          QDEPTH   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
`ifdef IF_STALL_COUNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] o_stall_cycles;
`endif

    fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .stall           (stall),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .instr_pc        (instr_pc)
`ifdef IF_STALL_COUNT_EN
        ,
        .stall_cycles    (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int lat      = 1;
    bit jitter   = 1'b0;
    int n_issued = 0;

    logic [31:0] pend_addr [$];
    int          pend_due  [$];

    logic        o_req_valid;
    logic [31:0] o_req_addr;
    logic        o_instr_valid;
    logic [31:0] o_instr;
    logic [31:0] o_instr_pc;

    function automatic logic [31:0] fdata(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // One clock cycle: memory model drives its response, outputs are sampled
    // mid-cycle, accepted requests are queued for a later in-order response.
    task automatic tick();
        if (!reset && pend_addr.size() > 0 && pend_due[0] <= cyc &&
            (!jitter || $urandom_range(0, 3) != 0)) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = fdata(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
        @(negedge clk);
        o_req_valid   = imem_req_valid;
        o_req_addr    = imem_req_addr;
        o_instr_valid = instr_valid;
        o_instr       = instr;
        o_instr_pc    = instr_pc;
`ifdef IF_STALL_COUNT_EN
        o_stall_cycles = stall_cycles;
`endif
        if (reset) begin
            pend_addr.delete();
            pend_due.delete();
        end else if (imem_req_valid && imem_req_ready) begin
            pend_addr.push_back(imem_req_addr);
            pend_due.push_back(cyc + lat + (jitter ? int'($urandom_range(0, 2)) : 0));
            n_issued++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Two reset cycles with quiet inputs, leaving reset low for the caller.
    task automatic do_reset();
        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        lat            = 1;
        jitter         = 1'b0;
        tick();
        tick();
        reset    = 1'b0;
        n_issued = 0;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        tick();
        n_checks++; if (o_req_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_req_valid got %0b exp 0", o_req_valid); end
        n_checks++; if (o_instr_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_instr_valid got %0b exp 0", o_instr_valid); end
        n_checks++; if (o_instr !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_instr got %h exp 0", o_instr); end
        n_checks++; if (o_instr_pc !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_instr_pc got %h exp 0", o_instr_pc); end
        tick();
        reset = 1'b0;
        tick();
        n_checks++; if (o_req_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL post_rst_req_valid got %0b exp 0", o_req_valid); end
        n_checks++; if (o_instr_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL post_rst_instr_valid got %0b exp 0", o_instr_valid); end
        tick();
        n_checks++; if (o_req_valid !== 1'b1 || o_req_addr !== RESET_PC) begin n_fail++; $display("[TB] FAIL first_req got v=%0b a=%h exp v=1 a=%h", o_req_valid, o_req_addr, RESET_PC); end
        tick();
        n_checks++; if (o_instr_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL early_instr_valid got %0b exp 0", o_instr_valid); end
        tick();
        n_checks++; if (o_instr_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL latency_instr_valid got %0b exp 1", o_instr_valid); end
        n_checks++; if (o_instr_pc !== RESET_PC || o_instr !== fdata(RESET_PC)) begin n_fail++; $display("[TB] FAIL first_instr got pc=%h d=%h exp pc=%h d=%h", o_instr_pc, o_instr, RESET_PC, fdata(RESET_PC)); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        logic [31:0] exp_req;
        int          pops;
        int          budget;
        $display("[TB] test_sequential");
        do_reset();
        exp_pc  = RESET_PC;
        exp_req = RESET_PC;
        pops    = 0;
        budget  = 60;
        while (pops < 12 && budget > 0) begin
            tick();
            budget--;
            if (o_req_valid && imem_req_ready) begin
                n_checks++; if (o_req_addr !== exp_req) begin n_fail++; $display("[TB] FAIL seq_req_addr got %h exp %h", o_req_addr, exp_req); end
                exp_req += 32'd4;
            end
            if (o_instr_valid) begin
                n_checks++; if (o_instr_pc !== exp_pc || o_instr !== fdata(exp_pc)) begin n_fail++; $display("[TB] FAIL seq_instr got pc=%h d=%h exp pc=%h d=%h", o_instr_pc, o_instr, exp_pc, fdata(exp_pc)); end
                exp_pc += 32'd4;
                pops++;
            end
        end
        n_checks++; if (pops != 12) begin n_fail++; $display("[TB] FAIL seq_timeout got %0d instrs exp 12", pops); end
    endtask

    task automatic test_stall();
        logic [31:0] exp_pc;
        int          pops;
        int          budget;
        $display("[TB] test_stall");
        do_reset();
        exp_pc = RESET_PC;
        pops   = 0;
        budget = 30;
        while (pops < 3 && budget > 0) begin
            tick();
            budget--;
            if (o_instr_valid) begin
                exp_pc += 32'd4;
                pops++;
            end
        end
        stall = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++; if (n_issued - pops > QDEPTH) begin n_fail++; $display("[TB] FAIL stall_inflight got %0d exp <= %0d", n_issued - pops, QDEPTH); end
            if (i >= 4) begin
                n_checks++; if (o_req_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_req_valid got %0b exp 0", o_req_valid); end
                n_checks++; if (o_instr_valid !== 1'b1 || o_instr_pc !== exp_pc) begin n_fail++; $display("[TB] FAIL stall_head got v=%0b pc=%h exp v=1 pc=%h", o_instr_valid, o_instr_pc, exp_pc); end
            end
        end
        stall  = 1'b0;
        pops   = 0;
        budget = 40;
        while (pops < 6 && budget > 0) begin
            tick();
            budget--;
            if (o_instr_valid) begin
                n_checks++; if (o_instr_pc !== exp_pc || o_instr !== fdata(exp_pc)) begin n_fail++; $display("[TB] FAIL stall_resume got pc=%h d=%h exp pc=%h d=%h", o_instr_pc, o_instr, exp_pc, fdata(exp_pc)); end
                exp_pc += 32'd4;
                pops++;
            end
        end
        n_checks++; if (pops != 6) begin n_fail++; $display("[TB] FAIL stall_timeout got %0d instrs exp 6", pops); end
    endtask

    task automatic test_redirect();
        bit seen_req;
        bit seen_instr;
        int budget;
        $display("[TB] test_redirect");
        do_reset();
        lat = 3;
        tick();
        tick();
        tick();
        n_checks++; if (pend_addr.size() != 2) begin n_fail++; $display("[TB] FAIL redir_inflight got %0d exp 2", pend_addr.size()); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        tick();
        n_checks++; if (o_req_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL redir_cycle_req got %0b exp 0", o_req_valid); end
        redirect_valid = 1'b0;
        tick();
        n_checks++; if (o_instr_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL redir_next_valid got %0b exp 0", o_instr_valid); end
        seen_req   = 1'b0;
        seen_instr = 1'b0;
        budget     = 20;
        while (!seen_instr && budget > 0) begin
            if (o_req_valid && !seen_req) begin
                n_checks++; if (o_req_addr !== 32'h0000_0100) begin n_fail++; $display("[TB] FAIL redir_req_addr got %h exp 00000100", o_req_addr); end
                seen_req = 1'b1;
            end
            if (o_instr_valid) begin
                n_checks++; if (o_instr_pc !== 32'h0000_0100 || o_instr !== fdata(32'h0000_0100)) begin n_fail++; $display("[TB] FAIL redir_instr got pc=%h d=%h exp pc=00000100 d=%h", o_instr_pc, o_instr, fdata(32'h0000_0100)); end
                seen_instr = 1'b1;
            end else begin
                tick();
                budget--;
            end
        end
        n_checks++; if (!seen_instr) begin n_fail++; $display("[TB] FAIL redir_timeout got no instr exp pc 00000100"); end
        lat = 1;
    endtask

    task automatic test_ready_low();
        $display("[TB] test_ready_low");
        do_reset();
        imem_req_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++; if (o_req_valid !== 1'b1 || o_req_addr !== RESET_PC) begin n_fail++; $display("[TB] FAIL ready_low_hold got v=%0b a=%h exp v=1 a=%h", o_req_valid, o_req_addr, RESET_PC); end
        end
        imem_req_ready = 1'b1;
        tick();
        n_checks++; if (o_req_valid !== 1'b1 || o_req_addr !== RESET_PC) begin n_fail++; $display("[TB] FAIL ready_accept got v=%0b a=%h exp v=1 a=%h", o_req_valid, o_req_addr, RESET_PC); end
        tick();
        n_checks++; if (o_req_addr !== RESET_PC + 32'd4) begin n_fail++; $display("[TB] FAIL ready_next_addr got %h exp %h", o_req_addr, RESET_PC + 32'd4); end
    endtask

    task automatic test_redirect_stall_full();
        bit seen_instr;
        int budget;
        $display("[TB] test_redirect_stall_full");
        do_reset();
        stall = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        n_checks++; if (o_instr_valid !== 1'b1 || o_req_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL full_state got iv=%0b rv=%0b exp iv=1 rv=0", o_instr_valid, o_req_valid); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_2002;
        tick();
        n_checks++; if (o_req_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rsf_cycle_req got %0b exp 0", o_req_valid); end
        redirect_valid = 1'b0;
        tick();
        n_checks++; if (o_instr_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rsf_flush got %0b exp 0", o_instr_valid); end
        n_checks++; if (o_req_valid !== 1'b1 || o_req_addr !== 32'h0000_2000) begin n_fail++; $display("[TB] FAIL rsf_req got v=%0b a=%h exp v=1 a=00002000", o_req_valid, o_req_addr); end
        stall      = 1'b0;
        seen_instr = 1'b0;
        budget     = 20;
        while (!seen_instr && budget > 0) begin
            tick();
            budget--;
            if (o_instr_valid) begin
                n_checks++; if (o_instr_pc !== 32'h0000_2000 || o_instr !== fdata(32'h0000_2000)) begin n_fail++; $display("[TB] FAIL rsf_instr got pc=%h d=%h exp pc=00002000 d=%h", o_instr_pc, o_instr, fdata(32'h0000_2000)); end
                seen_instr = 1'b1;
            end
        end
        n_checks++; if (!seen_instr) begin n_fail++; $display("[TB] FAIL rsf_timeout got no instr exp pc 00002000"); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc;
        int          pops;
        int          budget;
        $display("[TB] test_wrap");
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        tick();
        n_checks++; if (o_req_valid !== 1'b1 || o_req_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("[TB] FAIL wrap_req0 got v=%0b a=%h exp v=1 a=fffffffc", o_req_valid, o_req_addr); end
        tick();
        n_checks++; if (o_req_valid !== 1'b1 || o_req_addr !== 32'h0000_0000) begin n_fail++; $display("[TB] FAIL wrap_req1 got v=%0b a=%h exp v=1 a=00000000", o_req_valid, o_req_addr); end
        exp_pc = 32'hFFFF_FFFC;
        pops   = 0;
        budget = 20;
        while (pops < 3 && budget > 0) begin
            tick();
            budget--;
            if (o_instr_valid) begin
                n_checks++; if (o_instr_pc !== exp_pc || o_instr !== fdata(exp_pc)) begin n_fail++; $display("[TB] FAIL wrap_instr got pc=%h d=%h exp pc=%h d=%h", o_instr_pc, o_instr, exp_pc, fdata(exp_pc)); end
                exp_pc += 32'd4;
                pops++;
            end
        end
        n_checks++; if (pops != 3) begin n_fail++; $display("[TB] FAIL wrap_timeout got %0d instrs exp 3", pops); end
    endtask

    task automatic test_reset_midop();
        bit seen_instr;
        int budget;
        $display("[TB] test_reset_midop");
        do_reset();
        lat = 2;
        for (int i = 0; i < 6; i++) tick();
        reset = 1'b1;
        tick();
        n_checks++; if (o_req_valid !== 1'b0 || o_instr_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_valids got rv=%0b iv=%0b exp 0 0", o_req_valid, o_instr_valid); end
        n_checks++; if (o_instr !== 32'h0 || o_instr_pc !== 32'h0) begin n_fail++; $display("[TB] FAIL midrst_data got d=%h pc=%h exp 0 0", o_instr, o_instr_pc); end
        reset = 1'b0;
        tick();
        n_checks++; if (o_req_valid !== 1'b0 || o_instr_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_after got rv=%0b iv=%0b exp 0 0", o_req_valid, o_instr_valid); end
        seen_instr = 1'b0;
        budget     = 20;
        while (!seen_instr && budget > 0) begin
            tick();
            budget--;
            if (o_instr_valid) begin
                n_checks++; if (o_instr_pc !== RESET_PC || o_instr !== fdata(RESET_PC)) begin n_fail++; $display("[TB] FAIL midrst_instr got pc=%h d=%h exp pc=%h", o_instr_pc, o_instr, RESET_PC); end
                seen_instr = 1'b1;
            end
        end
        n_checks++; if (!seen_instr) begin n_fail++; $display("[TB] FAIL midrst_timeout got no instr exp pc %h", RESET_PC); end
        lat = 1;
    endtask

`ifdef IF_STALL_COUNT_EN
    task automatic test_stall_count();
        $display("[TB] test_stall_count");
        do_reset();
        tick();
        n_checks++; if (o_stall_cycles !== 32'd0) begin n_fail++; $display("[TB] FAIL stallcnt_reset got %0d exp 0", o_stall_cycles); end
        tick();
        tick();
        stall = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        stall = 1'b0;
        tick();
        n_checks++; if (o_stall_cycles !== 32'd7) begin n_fail++; $display("[TB] FAIL stallcnt_value got %0d exp 7", o_stall_cycles); end
    endtask
`endif

    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] exp_req;
        bit          after_redir;
        int          pre_out;
        int          pops;
        $display("[TB] test_random");
        do_reset();
        jitter      = 1'b1;
        exp_pc      = RESET_PC;
        exp_req     = RESET_PC;
        after_redir = 1'b0;
        pops        = 0;
        for (int i = 0; i < 1500; i++) begin
            stall          = ($urandom_range(0, 9) < 3);
            imem_req_ready = ($urandom_range(0, 9) < 7);
            redirect_valid = (i > 2) && ($urandom_range(0, 39) == 0);
            redirect_pc    = $urandom;
            pre_out        = pend_addr.size();
            tick();
            if (after_redir) begin
                n_checks++; if (o_instr_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rnd_post_redirect_valid got %0b exp 0", o_instr_valid); end
            end
            if (pre_out >= QDEPTH) begin
                n_checks++; if (o_req_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rnd_overissue got req_valid %0b with %0d in flight exp 0", o_req_valid, pre_out); end
            end
            if (redirect_valid) begin
                n_checks++; if (o_req_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rnd_redirect_req got %0b exp 0", o_req_valid); end
                exp_pc      = redirect_pc & ~32'h3;
                exp_req     = redirect_pc & ~32'h3;
                after_redir = 1'b1;
            end else begin
                after_redir = 1'b0;
                if (o_req_valid && imem_req_ready) begin
                    n_checks++; if (o_req_addr !== exp_req) begin n_fail++; $display("[TB] FAIL rnd_req_addr got %h exp %h", o_req_addr, exp_req); end
                    exp_req += 32'd4;
                end
                if (o_instr_valid && !stall) begin
                    n_checks++; if (o_instr_pc !== exp_pc || o_instr !== fdata(exp_pc)) begin n_fail++; $display("[TB] FAIL rnd_instr got pc=%h d=%h exp pc=%h d=%h", o_instr_pc, o_instr, exp_pc, fdata(exp_pc)); end
                    exp_pc += 32'd4;
                    pops++;
                end
            end
        end
        n_checks++; if (pops < 100) begin n_fail++; $display("[TB] FAIL rnd_progress got %0d instrs exp >= 100", pops); end
        stall          = 1'b0;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        jitter         = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_ready_low();
        test_redirect_stall_full();
        test_wrap();
        test_reset_midop();
`ifdef IF_STALL_COUNT_EN
        test_stall_count();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got no completion exp finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
